decode_issue_stage: RTL and testbench
=====================================

# decode_issue_stage

Parametrised decode stage with an integrated register file, HI/LO registers, a per-register pending-write scoreboard and a registered ID/EX output with valid/ready handshake. Sits between fetch and execute. Stalls on RAW hazards locally, resolves branches and jumps in decode, and supports a flush from downstream.

## Interface
- XLEN, 32: data width of registers, immediates and PCs.
- NREGS, 32: architectural register count; id width RW = clog2(NREGS); register 0 reads as 0.
- CNT_W, 2: width of each scoreboard pending counter (max 2^CNT_W-1 in-flight writes per register).
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid / in_ready  in / out  1  fetch handshake.
- instruction  in  32  MIPS instruction word.
- pc_plus_four  in  XLEN  PC of the instruction plus 4.
- wb_en, wb_id, wb_value  in  1, RW, XLEN  writeback port.
- hilo_we, hi_w, lo_w  in  1, XLEN, XLEN  HI/LO write from divide/multiply writeback.
- flush  in  1  discard the ID/EX register contents.
- out_valid / out_ready  out / in  1  execute handshake.
- out_rs_value, out_rt_value, out_imm, out_pc_plus_four  out  XLEN  registered operands.
- out_rs_id, out_rt_id, out_dst_id  out  RW  registered ids.
- out_dst_we  out  1  the issued instruction writes out_dst_id.
- redirect_valid  out  1  taken branch/jump, combinational, same cycle as acceptance.
- redirect_target  out  XLEN  new PC when redirect_valid.

## Operation
- Destination: opcode 0 → rd, except funct 0x08 (JR), 0x0C (SYSCALL), 0x18–0x1B (MULT/DIV) → no write; opcodes 0x08–0x0F and 0x20–0x25 → rt; 0x03 (JAL) → 31. Destination 0 forces out_dst_we=0.
- Immediate: sign-extended, except zero-extended for 0x0C–0x0E. LUI (0x0F): imm<<16.
- Register file read with write-through: if wb_en and wb_id equals the read id (≠0), wb_value is returned. Same for HI/LO with hilo_we.
- MFHI (funct 0x10) / MFLO (0x12): rs value replaced by HI/LO.
- JAL: rs value = pc_plus_four, rt value = 0.
- Scoreboard: pending[dst]++ on acceptance with out_dst_we; pending[wb_id]-- on wb_en with wb_id≠0; simultaneous ++/-- on one register leaves it unchanged. On flush with out_valid and out_dst_we, pending[out_dst_id]-- (this combines with the other updates).
- Hazard (stall): a used source (rs, and rt for R-type/BEQ/BNE/stores 0x28–0x2B) has pending>0, unless pending==1 and wb_en writes it this cycle. Also stall when pending[dst] is at maximum. MFHI/MFLO and divides do not use the scoreboard; HI/LO ordering is the hazard unit's job.
- in_ready = !hazard && !flush && (!out_valid || out_ready). Acceptance = in_valid && in_ready.
- Branches, taken only on acceptance:
  - BEQ (0x04) / BNE (0x05): compare rs and rt; target = pc_plus_four + (sext imm<<2).
  - J / JAL: target = {pc_plus_four[XLEN-1:28], instr[25:0], 2'b00}.
  - JR: target = rs value.
  - Fetch discards its current slot on redirect_valid. There is no delay slot.

## Timing
- Reset (async, any time): out_valid=0, all out_* = 0, every register, HI, LO and pending counter = 0. redirect_valid=0 while reset is active.
- Latency: acceptance at cycle N → out_valid at N+1 with operands. The ID/EX register holds while out_valid && !out_ready.
- flush at cycle N: out_valid=0 at N+1, and nothing is accepted at N.
- The register file writes at the edge. A read in the same cycle as the write sees the new value through the bypass.
- Decrementing pending at 0 is illegal. It is ignored, and the bench asserts on it.

## Test plan
- Reset mid-stream: pulse reset_n low with out_valid=1 → out_valid=0 immediately, then a read of r5 returns 0.
- RAW stall: issue ADDI r5,r0,7, then ADD r6,r5,r5 → in_ready=0 until wb_en wb_id=5 wb_value=7. The ADD is accepted in that same cycle with rs=rt=7.
- Back-pressure: out_ready=0 for 3 cycles → out_* stable, in_ready=0, and no scoreboard change.
- BEQ taken: rs=rt=3, pc_plus_four=0x104, imm=0x0004 → redirect_valid=1, target 0x114. With rt=4 → no redirect.
- JAL at pc_plus_four=0x0040_0008, index 0x010_0000 → target 0x0040_0000, out_dst_id=31, out_rs_value=0x0040_0008.
- Flush: issue ADDI r7, then assert flush before out_ready → pending[7] returns to 0, and a following read of r7 does not stall.

Source files
------------

// File: rtl/decode_issue_stage_if.sv
// Bundle between fetch, writeback and execute for decode_issue_stage.
// The slave modport is the decode stage's view. The master modport is the view
// of whatever drives it: fetch, writeback and execute, or a testbench.
//   fetch     : in_valid/in_ready, instruction, pc_plus_four
//   writeback : wb_en/wb_id/wb_value, hilo_we/hi_w/lo_w
//   execute   : out_valid/out_ready, out_* operands and ids, flush
//   redirect  : redirect_valid/redirect_target back to fetch
interface decode_issue_stage_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int RW = $clog2(NREGS);

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic [XLEN-1:0] pc_plus_four;

    logic            wb_en;
    logic [RW-1:0]   wb_id;
    logic [XLEN-1:0] wb_value;
    logic            hilo_we;
    logic [XLEN-1:0] hi_w;
    logic [XLEN-1:0] lo_w;

    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_rs_value;
    logic [XLEN-1:0] out_rt_value;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_pc_plus_four;
    logic [RW-1:0]   out_rs_id;
    logic [RW-1:0]   out_rt_id;
    logic [RW-1:0]   out_dst_id;
    logic            out_dst_we;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;

    modport slave (
        input  in_valid, instruction, pc_plus_four,
        input  wb_en, wb_id, wb_value, hilo_we, hi_w, lo_w,
        input  flush, out_ready,
        output in_ready, out_valid, out_rs_value, out_rt_value, out_imm,
        output out_pc_plus_four, out_rs_id, out_rt_id, out_dst_id, out_dst_we,
        output redirect_valid, redirect_target
    );

    modport master (
        output in_valid, instruction, pc_plus_four,
        output wb_en, wb_id, wb_value, hilo_we, hi_w, lo_w,
        output flush, out_ready,
        input  in_ready, out_valid, out_rs_value, out_rt_value, out_imm,
        input  out_pc_plus_four, out_rs_id, out_rt_id, out_dst_id, out_dst_we,
        input  redirect_valid, redirect_target
    );
endinterface

// File: rtl/decode_issue_stage.sv
// MIPS decode/issue stage. It holds the register file, HI/LO and a
// pending-write scoreboard, and drives a registered ID/EX output with a
// valid/ready handshake. Branches and jumps resolve here and drive a
// combinational redirect in the acceptance cycle. There is no delay slot.
// Ports:
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   bus            : decode_issue_stage_if.slave (fetch, writeback, execute, redirect)
module decode_issue_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    decode_issue_stage_if.slave bus
);
    localparam int              RW      = $clog2(NREGS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0]  rf_q [NREGS];
    logic [XLEN-1:0]  rf_d [NREGS];
    logic [CNT_W-1:0] pending_q [NREGS];
    logic [CNT_W-1:0] pending_d [NREGS];
    logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_rs_value_q, out_rs_value_d;
    logic [XLEN-1:0] out_rt_value_q, out_rt_value_d;
    logic [XLEN-1:0] out_imm_q, out_imm_d;
    logic [XLEN-1:0] out_ppf_q, out_ppf_d;
    logic [RW-1:0]   out_rs_id_q, out_rs_id_d;
    logic [RW-1:0]   out_rt_id_q, out_rt_id_d;
    logic [RW-1:0]   out_dst_id_q, out_dst_id_d;
    logic            out_dst_we_q, out_dst_we_d;

    // Instruction fields
    logic [5:0]    opcode, funct;
    logic [RW-1:0] rs_id, rt_id, rd_id;
    assign opcode = bus.instruction[31:26];
    assign funct  = bus.instruction[5:0];
    assign rs_id  = RW'(bus.instruction[25:21]);
    assign rt_id  = RW'(bus.instruction[20:16]);
    assign rd_id  = RW'(bus.instruction[15:11]);

    logic is_rtype, is_mfhi, is_mflo, is_muldiv, is_jr, is_j, is_jal;
    logic is_beq, is_bne, is_store, no_sb, use_rs, use_rt;
    assign is_rtype  = (opcode == 6'h00);
    assign is_mfhi   = is_rtype && (funct == 6'h10);
    assign is_mflo   = is_rtype && (funct == 6'h12);
    assign is_muldiv = is_rtype && (funct inside {[6'h18:6'h1B]});
    assign is_jr     = is_rtype && (funct == 6'h08);
    assign is_j      = (opcode == 6'h02);
    assign is_jal    = (opcode == 6'h03);
    assign is_beq    = (opcode == 6'h04);
    assign is_bne    = (opcode == 6'h05);
    assign is_store  = (opcode inside {[6'h28:6'h2B]});
    // HI/LO producers and consumers are ordered by the hazard unit, not by
    // this scoreboard. J/JAL carry jump-index bits in the rs field, so they
    // must not look it up.
    assign no_sb  = is_mfhi || is_mflo || is_muldiv;
    assign use_rs = !no_sb && !is_j && !is_jal;
    assign use_rt = (is_rtype && !no_sb) || is_beq || is_bne || is_store;

    // Destination decode
    logic [RW-1:0] dst_id;
    logic          dst_we;
    always_comb begin
        dst_id = '0;
        dst_we = 1'b0;
        if (is_rtype) begin
            if (!(is_jr || funct == 6'h0C || is_muldiv)) begin
                dst_id = rd_id;
                dst_we = 1'b1;
            end
        end else if (opcode inside {[6'h08:6'h0F], [6'h20:6'h25]}) begin
            dst_id = rt_id;
            dst_we = 1'b1;
        end else if (is_jal) begin
            dst_id = RW'(5'd31);
            dst_we = 1'b1;
        end
        if (dst_id == '0) begin
            dst_we = 1'b0;
        end
    end

    // Immediate
    logic [XLEN-1:0] imm_sext, imm_val;
    assign imm_sext = {{(XLEN-16){bus.instruction[15]}}, bus.instruction[15:0]};
    always_comb begin
        imm_val = imm_sext;
        if (opcode inside {[6'h0C:6'h0E]}) begin
            imm_val = {{(XLEN-16){1'b0}}, bus.instruction[15:0]};
        end else if (opcode == 6'h0F) begin
            imm_val = XLEN'({bus.instruction[15:0], 16'h0000});
        end
    end

    // Operand read. Writeback in the same cycle bypasses the array.
    logic [XLEN-1:0] rs_rf, rt_rf, hi_rd, lo_rd, rs_val, rt_val;
    assign rs_rf = (rs_id == '0) ? '0 :
                   (bus.wb_en && bus.wb_id == rs_id) ? bus.wb_value : rf_q[rs_id];
    assign rt_rf = (rt_id == '0) ? '0 :
                   (bus.wb_en && bus.wb_id == rt_id) ? bus.wb_value : rf_q[rt_id];
    assign hi_rd = bus.hilo_we ? bus.hi_w : hi_q;
    assign lo_rd = bus.hilo_we ? bus.lo_w : lo_q;

    always_comb begin
        rs_val = rs_rf;
        rt_val = rt_rf;
        if (is_mfhi) begin
            rs_val = hi_rd;
        end else if (is_mflo) begin
            rs_val = lo_rd;
        end else if (is_jal) begin
            rs_val = bus.pc_plus_four;
            rt_val = '0;
        end
    end

    // A source is free when nothing is pending, or when its single
    // outstanding write lands this very cycle (picked up by the bypass).
    logic rs_busy, rt_busy, dst_full, hazard, accept, taken;
    assign rs_busy = (pending_q[rs_id] != '0) &&
                     !((pending_q[rs_id] == CNT_W'(1)) && bus.wb_en && bus.wb_id == rs_id);
    assign rt_busy = (pending_q[rt_id] != '0) &&
                     !((pending_q[rt_id] == CNT_W'(1)) && bus.wb_en && bus.wb_id == rt_id);
    assign dst_full = dst_we && (pending_q[dst_id] == CNT_MAX);
    assign hazard   = (use_rs && rs_busy) || (use_rt && rt_busy) || dst_full;

    assign bus.in_ready = !hazard && !bus.flush && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // Branch and jump resolution
    always_comb begin
        taken               = 1'b0;
        bus.redirect_target = '0;
        if (is_beq || is_bne) begin
            taken = is_beq ? (rs_val == rt_val) : (rs_val != rt_val);
            bus.redirect_target = bus.pc_plus_four + {imm_sext[XLEN-3:0], 2'b00};
        end else if (is_j || is_jal) begin
            taken = 1'b1;
            bus.redirect_target = {bus.pc_plus_four[XLEN-1:28], bus.instruction[25:0], 2'b00};
        end else if (is_jr) begin
            taken = 1'b1;
            bus.redirect_target = rs_val;
        end
    end
    assign bus.redirect_valid = accept && taken && reset_n;

    // State next-values: register file, HI/LO, scoreboard
    int nxt_cnt;
    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        nxt_cnt = 0;
        if (bus.hilo_we) begin
            hi_d = bus.hi_w;
            lo_d = bus.lo_w;
        end
        for (int i = 0; i < NREGS; i++) begin
            rf_d[i] = rf_q[i];
            if (bus.wb_en && bus.wb_id == RW'(i) && i != 0) begin
                rf_d[i] = bus.wb_value;
            end
            // Increment on issue, decrement on writeback and on a flushed
            // in-flight write. The sum is clamped so that a decrement at
            // zero is dropped.
            nxt_cnt = int'(pending_q[i])
                    + ((accept && dst_we && dst_id == RW'(i)) ? 1 : 0)
                    - ((bus.wb_en && bus.wb_id == RW'(i) && i != 0) ? 1 : 0)
                    - ((bus.flush && out_valid_q && out_dst_we_q &&
                        out_dst_id_q == RW'(i)) ? 1 : 0);
            if (nxt_cnt < 0) begin
                nxt_cnt = 0;
            end else if (nxt_cnt > int'(CNT_MAX)) begin
                nxt_cnt = int'(CNT_MAX);
            end
            pending_d[i] = CNT_W'(nxt_cnt);
        end
    end

    // ID/EX register
    always_comb begin
        out_valid_d    = out_valid_q;
        out_rs_value_d = out_rs_value_q;
        out_rt_value_d = out_rt_value_q;
        out_imm_d      = out_imm_q;
        out_ppf_d      = out_ppf_q;
        out_rs_id_d    = out_rs_id_q;
        out_rt_id_d    = out_rt_id_q;
        out_dst_id_d   = out_dst_id_q;
        out_dst_we_d   = out_dst_we_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d    = 1'b1;
            out_rs_value_d = rs_val;
            out_rt_value_d = rt_val;
            out_imm_d      = imm_val;
            out_ppf_d      = bus.pc_plus_four;
            out_rs_id_d    = rs_id;
            out_rt_id_d    = rt_id;
            out_dst_id_d   = dst_id;
            out_dst_we_d   = dst_we;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i]      <= '0;
                pending_q[i] <= '0;
            end
            hi_q           <= '0;
            lo_q           <= '0;
            out_valid_q    <= 1'b0;
            out_rs_value_q <= '0;
            out_rt_value_q <= '0;
            out_imm_q      <= '0;
            out_ppf_q      <= '0;
            out_rs_id_q    <= '0;
            out_rt_id_q    <= '0;
            out_dst_id_q   <= '0;
            out_dst_we_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i]      <= rf_d[i];
                pending_q[i] <= pending_d[i];
            end
            hi_q           <= hi_d;
            lo_q           <= lo_d;
            out_valid_q    <= out_valid_d;
            out_rs_value_q <= out_rs_value_d;
            out_rt_value_q <= out_rt_value_d;
            out_imm_q      <= out_imm_d;
            out_ppf_q      <= out_ppf_d;
            out_rs_id_q    <= out_rs_id_d;
            out_rt_id_q    <= out_rt_id_d;
            out_dst_id_q   <= out_dst_id_d;
            out_dst_we_q   <= out_dst_we_d;
        end
    end

    assign bus.out_valid        = out_valid_q;
    assign bus.out_rs_value     = out_rs_value_q;
    assign bus.out_rt_value     = out_rt_value_q;
    assign bus.out_imm          = out_imm_q;
    assign bus.out_pc_plus_four = out_ppf_q;
    assign bus.out_rs_id        = out_rs_id_q;
    assign bus.out_rt_id        = out_rt_id_q;
    assign bus.out_dst_id       = out_dst_id_q;
    assign bus.out_dst_we       = out_dst_we_q;
endmodule

// File: tb/tb_decode_issue_stage.sv
module tb_decode_issue_stage;
    typedef struct packed {
        logic [31:0] rs_v;
        logic [31:0] rt_v;
        logic [31:0] imm;
        logic [31:0] ppf;
        logic [4:0]  rs_id;
        logic [4:0]  rt_id;
        logic [4:0]  dst_id;
        logic        dst_we;
    } exp_t;

    logic clk;
    logic reset_n;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    int   tb_pend[32];

    decode_issue_stage_if #(.XLEN(32), .NREGS(32)) bus ();

    decode_issue_stage #(.XLEN(32), .NREGS(32), .CNT_W(2)) dut (
        .clock  (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic exp_t mk(input logic [31:0] rs_v, input logic [31:0] rt_v,
                                input logic [31:0] imm, input logic [31:0] ppf,
                                input logic [4:0] rs_id, input logic [4:0] rt_id,
                                input logic [4:0] dst_id, input logic dst_we);
        exp_t e;
        e.rs_v = rs_v; e.rt_v = rt_v; e.imm = imm; e.ppf = ppf;
        e.rs_id = rs_id; e.rt_id = rt_id; e.dst_id = dst_id; e.dst_we = dst_we;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: drops the head entry when a valid output is flushed, pops and
    // compares whenever execute takes an output.
    initial begin
        exp_t e;
        int   n_out = 0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (bus.out_valid && bus.flush) begin
                    if (exp_q.size() > 0) e = exp_q.pop_front();
                end else if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("out%0d.rs_value", n_out), bus.out_rs_value, e.rs_v);
                        chk($sformatf("out%0d.rt_value", n_out), bus.out_rt_value, e.rt_v);
                        chk($sformatf("out%0d.imm", n_out), bus.out_imm, e.imm);
                        chk($sformatf("out%0d.pc_plus_four", n_out), bus.out_pc_plus_four, e.ppf);
                        chk($sformatf("out%0d.ids", n_out),
                            32'({bus.out_rs_id, bus.out_rt_id, bus.out_dst_id, bus.out_dst_we}),
                            32'({e.rs_id, e.rt_id, e.dst_id, e.dst_we}));
                        n_out++;
                    end
                end
            end
        end
    end

    // Presents one instruction; called at posedge+1, returns at posedge+1.
    task automatic issue(input logic [31:0] ins, input logic [31:0] ppf, input exp_t e,
                         input logic exp_redir, input logic [31:0] exp_tgt, input int max_wait);
        int waited = 0;
        bit ok = 0;
        bus.in_valid     = 1'b1;
        bus.instruction  = ins;
        bus.pc_plus_four = ppf;
        while (!ok && waited < max_wait) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1;
                chk($sformatf("redirect_valid@%08h", ins), 32'(bus.redirect_valid), 32'(exp_redir));
                if (exp_redir) chk($sformatf("redirect_target@%08h", ins), bus.redirect_target, exp_tgt);
                exp_q.push_back(e);
                if (e.dst_we) tb_pend[e.dst_id]++;
            end else begin
                waited++;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk($sformatf("accepted@%08h", ins), 32'(ok), 32'd1);
    endtask

    task automatic wb(input logic [4:0] id, input logic [31:0] v);
        assert (tb_pend[id] != 0) else $error("writeback to r%0d with no write pending", id);
        if (tb_pend[id] > 0) tb_pend[id]--;
        bus.wb_en = 1'b1; bus.wb_id = id; bus.wb_value = v;
        @(posedge clk); #1;
        bus.wb_en = 1'b0;
    endtask

    task automatic load_reg(input logic [4:0] id, input logic [15:0] v);
        issue(itype(6'h08, 5'd0, id, v), 32'h0000_0080,
              mk(0, 0, 32'(v), 32'h0000_0080, 5'd0, id, id, 1'b1), 1'b0, 0, 4);
        wb(id, 32'(v));
    endtask

    initial begin
        int w;
        for (int i = 0; i < 32; i++) tb_pend[i] = 0;
        reset_n = 1'b0;
        bus.in_valid = 0; bus.instruction = 0; bus.pc_plus_four = 0;
        bus.wb_en = 0; bus.wb_id = 0; bus.wb_value = 0;
        bus.hilo_we = 0; bus.hi_w = 0; bus.lo_w = 0;
        bus.flush = 0; bus.out_ready = 1'b1;

        // Reset state, with a J presented so the redirect gating is visible
        bus.in_valid = 1'b1;
        bus.instruction = {6'h02, 26'h000_0040};
        repeat (2) @(negedge clk);
        chk("rst.out_valid", 32'(bus.out_valid), 0);
        chk("rst.out_rs_value", bus.out_rs_value, 0);
        chk("rst.out_imm", bus.out_imm, 0);
        chk("rst.out_ids_we", 32'({bus.out_rs_id, bus.out_rt_id, bus.out_dst_id, bus.out_dst_we}), 0);
        chk("rst.redirect_valid", 32'(bus.redirect_valid), 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // RAW stall on r5, released by the same-cycle writeback
        issue(itype(6'h08, 5'd0, 5'd5, 16'd7), 32'h100,
              mk(0, 0, 7, 32'h100, 5'd0, 5'd5, 5'd5, 1'b1), 1'b0, 0, 4);
        bus.in_valid = 1'b1; bus.instruction = rtype(5'd5, 5'd5, 5'd6, 6'h20);
        bus.pc_plus_four = 32'h104;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); chk("raw.stall_in_ready", 32'(bus.in_ready), 0);
            @(posedge clk); #1;
        end
        bus.wb_en = 1'b1; bus.wb_id = 5'd5; bus.wb_value = 32'd7;
        @(negedge clk);
        chk("raw.release_in_ready", 32'(bus.in_ready), 1);
        exp_q.push_back(mk(7, 7, 32'h3020, 32'h104, 5'd5, 5'd5, 5'd6, 1'b1));
        tb_pend[5]--; tb_pend[6]++;
        @(posedge clk); #1;
        bus.wb_en = 1'b0; bus.in_valid = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Back-pressure: ORI held for 3 cycles, LUI waits
        bus.out_ready = 1'b0;
        issue(itype(6'h0D, 5'd5, 5'd8, 16'hF00F), 32'h108,
              mk(7, 0, 32'h0000_F00F, 32'h108, 5'd5, 5'd8, 5'd8, 1'b1), 1'b0, 0, 4);
        bus.in_valid = 1'b1; bus.instruction = itype(6'h0F, 5'd0, 5'd9, 16'h1234);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp.in_ready", 32'(bus.in_ready), 0);
            chk("bp.out_valid", 32'(bus.out_valid), 1);
            chk("bp.out_rs_value", bus.out_rs_value, 7);
            chk("bp.out_imm", bus.out_imm, 32'h0000_F00F);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        issue(itype(6'h0F, 5'd0, 5'd9, 16'h1234), 32'h10C,
              mk(0, 0, 32'h1234_0000, 32'h10C, 5'd0, 5'd9, 5'd9, 1'b1), 1'b0, 0, 1);
        wb(5'd6, 32'd14);
        wb(5'd8, 32'h0000_F00F);
        wb(5'd9, 32'h1234_0000);

        // Branches
        load_reg(5'd1, 16'd3);
        load_reg(5'd2, 16'd3);
        load_reg(5'd3, 16'd4);
        issue(itype(6'h04, 5'd1, 5'd2, 16'h0004), 32'h104,
              mk(3, 3, 4, 32'h104, 5'd1, 5'd2, 5'd0, 1'b0), 1'b1, 32'h114, 4);
        issue(itype(6'h04, 5'd1, 5'd3, 16'h0004), 32'h108,
              mk(3, 4, 4, 32'h108, 5'd1, 5'd3, 5'd0, 1'b0), 1'b0, 0, 4);
        issue(itype(6'h05, 5'd1, 5'd3, 16'hFFFE), 32'h200,
              mk(3, 4, 32'hFFFF_FFFE, 32'h200, 5'd1, 5'd3, 5'd0, 1'b0), 1'b1, 32'h1F8, 4);
        issue({6'h03, 26'h010_0000}, 32'h0040_0008,
              mk(32'h0040_0008, 0, 0, 32'h0040_0008, 5'd0, 5'd16, 5'd31, 1'b1),
              1'b1, 32'h0040_0000, 4);
        wb(5'd31, 32'h0040_0008);
        issue(rtype(5'd1, 5'd0, 5'd0, 6'h08), 32'h300,
              mk(3, 0, 8, 32'h300, 5'd1, 5'd0, 5'd0, 1'b0), 1'b1, 32'h3, 4);

        // HI/LO: registered read, then same-cycle bypass
        bus.hilo_we = 1'b1; bus.hi_w = 32'h1111; bus.lo_w = 32'h2222;
        @(posedge clk); #1;
        bus.hilo_we = 1'b0;
        issue(rtype(5'd0, 5'd0, 5'd10, 6'h10), 32'h400,
              mk(32'h1111, 0, 32'h5010, 32'h400, 5'd0, 5'd0, 5'd10, 1'b1), 1'b0, 0, 4);
        bus.hilo_we = 1'b1; bus.hi_w = 32'h3333; bus.lo_w = 32'h4444;
        issue(rtype(5'd0, 5'd0, 5'd11, 6'h12), 32'h404,
              mk(32'h4444, 0, 32'h5812, 32'h404, 5'd0, 5'd0, 5'd11, 1'b1), 1'b0, 0, 4);
        bus.hilo_we = 1'b0;
        wb(5'd10, 32'h1111);
        wb(5'd11, 32'h4444);

        // Pending counter saturation on r15
        for (int k = 1; k <= 3; k++) begin
            issue(itype(6'h08, 5'd0, 5'd15, 16'(k)), 32'h500,
                  mk(0, 0, 32'(k), 32'h500, 5'd0, 5'd15, 5'd15, 1'b1), 1'b0, 0, 4);
        end
        bus.in_valid = 1'b1; bus.instruction = itype(6'h08, 5'd0, 5'd15, 16'd4);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); chk("sat.in_ready", 32'(bus.in_ready), 0);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        wb(5'd15, 32'd1); wb(5'd15, 32'd2); wb(5'd15, 32'd3);

        // Flush of an in-flight write to r7
        bus.out_ready = 1'b0;
        issue(itype(6'h08, 5'd0, 5'd7, 16'd1), 32'h600,
              mk(0, 0, 1, 32'h600, 5'd0, 5'd7, 5'd7, 1'b1), 1'b0, 0, 4);
        bus.flush = 1'b1;
        bus.in_valid = 1'b1; bus.instruction = rtype(5'd7, 5'd7, 5'd12, 6'h20);
        @(negedge clk);
        chk("flush.in_ready", 32'(bus.in_ready), 0);
        tb_pend[7]--;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        chk("flush.out_valid", 32'(bus.out_valid), 0);
        @(posedge clk); #1;
        issue(rtype(5'd7, 5'd7, 5'd12, 6'h20), 32'h604,
              mk(0, 0, 32'h6020, 32'h604, 5'd7, 5'd7, 5'd12, 1'b1), 1'b0, 0, 1);
        wb(5'd12, 32'd0);

        // Reset mid-stream with an output pending
        bus.out_ready = 1'b0;
        issue(itype(6'h08, 5'd0, 5'd13, 16'd5), 32'h700,
              mk(0, 0, 5, 32'h700, 5'd0, 5'd13, 5'd13, 1'b1), 1'b0, 0, 4);
        chk("midrst.out_valid_before", 32'(bus.out_valid), 1);
        reset_n = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 32; i++) tb_pend[i] = 0;
        bus.in_valid = 1'b1; bus.instruction = itype(6'h04, 5'd0, 5'd0, 16'd1);
        #1;
        chk("midrst.out_valid", 32'(bus.out_valid), 0);
        chk("midrst.redirect_valid", 32'(bus.redirect_valid), 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        issue(rtype(5'd5, 5'd0, 5'd14, 6'h25), 32'h800,
              mk(0, 0, 32'h7025, 32'h800, 5'd5, 5'd0, 5'd14, 1'b1), 1'b0, 0, 2);
        wb(5'd14, 32'd0);

        w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("queue_drain", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
